// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg -- shared definitions for the 4-way arbiter slice.
//   NUM_REQ : number of requesters (4)
//   IDX_W   : width of a requester index (2)
//   state_t : arbiter FSM states {IDLE, BUSY}
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : arb_pkg

// File: rtl/prio_enc4.sv
// ---------------------------------------------------------------------------
// prio_enc4 -- combinational 4-bit priority search; the lowest set bit wins.
// The caller rotates/reverses its request vector so that bit 0 is the
// requester that should be considered first, then maps the index back.
// Ports:
//   vec   in  [3:0]  candidate vector (already rotated/masked)
//   idx   out [1:0]  position of the lowest set bit (0 when vec == 0)
//   valid out        vec has at least one bit set
// ---------------------------------------------------------------------------
module prio_enc4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Walk downward so the lowest set bit is the last (winning) write.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : prio_enc4

// File: rtl/arb_rr_4.sv
// ---------------------------------------------------------------------------
// arb_rr_4 -- 4-requester arbiter with a bounded hold time.
// A requester keeps the grant while it keeps requesting, for at most
// MAX_HOLD consecutive cycles. On release the next winner is granted at the
// same edge; on expiry the current owner is excluded from that one search.
// All outputs are registered (one cycle from req to grant).
//
// Build option:
//   ARB_RR_4_ROUND_ROBIN_EN  defined   -> round-robin, search starts after
//                                         the most recent grant
//                            undefined -> fixed priority, 3 highest, 0 lowest
// Parameters:
//   MAX_HOLD  max consecutive grant cycles per owner, 1..256
// Ports:
//   clk        in        clock, rising edge
//   rst        in        asynchronous active-high reset
//   req        in  [3:0] request vector
//   gnt        out [3:0] one-hot grant, zero when idle
//   gnt_idx    out [1:0] index of the granted requester, 0 when idle
//   gnt_valid  out       a grant is active
// ---------------------------------------------------------------------------
module arb_rr_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0]   gnt_idx_reg, gnt_idx_next;
    logic               gnt_valid_reg, gnt_valid_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;

    logic               expired;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] enc_vec;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic [IDX_W-1:0]   win_idx;

    // The owner has used its last allowed cycle once the counter reaches
    // MAX_HOLD-1 (always true for MAX_HOLD=1, giving one-cycle grants).
    assign expired = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));

    // On expiry the owner sits out this one search. On a voluntary drop its
    // req bit is already 0, so no masking is needed there.
    assign cand = (state_reg == BUSY && expired) ? (req & ~gnt_reg) : req;

`ifdef ARB_RR_4_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_idx_reg, last_idx_next;

    // Rotate so that encoder bit 0 is requester (last_idx+1) mod 4.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [IDX_W-1:0] src;
        assign src         = last_idx_reg + IDX_W'(gi + 1);
        assign enc_vec[gi] = cand[src];
    end
    assign win_idx = enc_idx + last_idx_reg + IDX_W'(1);
`else
    // Reverse so that encoder bit 0 is requester 3 (highest priority).
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rev
        assign enc_vec[gi] = cand[NUM_REQ-1-gi];
    end
    assign win_idx = IDX_W'(NUM_REQ - 1) - enc_idx;
`endif

    prio_enc4 u_prio_enc4 (
        .vec   (enc_vec),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_idx_next   = gnt_idx_reg;
        gnt_valid_next = gnt_valid_reg;
        hold_cnt_next  = hold_cnt_reg;

        if (state_reg == BUSY && req[gnt_idx_reg] && !expired) begin
            hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end else if (enc_valid) begin
            // New grant: from IDLE, or back-to-back on release.
            state_next          = BUSY;
            gnt_next            = '0;
            gnt_next[win_idx]   = 1'b1;
            gnt_idx_next        = win_idx;
            gnt_valid_next      = 1'b1;
            hold_cnt_next       = '0;
        end else begin
            state_next     = IDLE;
            gnt_next       = '0;
            gnt_idx_next   = '0;
            gnt_valid_next = 1'b0;
            hold_cnt_next  = '0;
        end
    end

`ifdef ARB_RR_4_ROUND_ROBIN_EN
    assign last_idx_next = (gnt_valid_next && hold_cnt_next == '0) ? gnt_idx_next
                                                                   : last_idx_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            hold_cnt_reg  <= '0;
`ifdef ARB_RR_4_ROUND_ROBIN_EN
            last_idx_reg  <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= gnt_valid_next;
            hold_cnt_reg  <= hold_cnt_next;
`ifdef ARB_RR_4_ROUND_ROBIN_EN
            last_idx_reg  <= last_idx_next;
`endif
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;

endmodule : arb_rr_4

// File: tb/tb_arb_rr_4.sv
// ---------------------------------------------------------------------------
// tb_arb_rr_4 -- self-checking bench for arb_rr_4. Two instances share the
// same stimulus: MAX_HOLD=8 (index 0) and MAX_HOLD=2 (index 1). A behavioural
// model (owner / cycles-held / last winner) predicts both every cycle.
// ---------------------------------------------------------------------------
module tb_arb_rr_4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt8, gnt2;
    logic [1:0] idx8, idx2;
    logic       v8, v2;

    int n_pass  = 0;
    int n_total = 0;

    int m_owner [2];
    int m_held  [2];
    int m_last  [2];
    int m_limit [2] = '{8, 2};

    always #5 clk = ~clk;

    arb_rr_4 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(v8)
    );

    arb_rr_4 #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(v2)
    );

    // ---------------- reference model ----------------
    function automatic int pick(input logic [3:0] c, input int last);
`ifdef ARB_RR_4_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (c[(last + k) % 4]) return (last + k) % 4;
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (c[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_last[d]  = 3;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] c;
        for (int d = 0; d < 2; d++) begin
            if (m_owner[d] < 0) begin
                if (r != 4'b0000) begin
                    m_owner[d] = pick(r, m_last[d]);
                    m_held[d]  = 1;
                    m_last[d]  = m_owner[d];
                end
            end else if (r[m_owner[d]] && m_held[d] < m_limit[d]) begin
                m_held[d]++;
            end else begin
                c = r;
                if (m_held[d] == m_limit[d]) c[m_owner[d]] = 1'b0;
                if (c != 4'b0000) begin
                    m_owner[d] = pick(c, m_last[d]);
                    m_held[d]  = 1;
                    m_last[d]  = m_owner[d];
                end else begin
                    m_owner[d] = -1;
                    m_held[d]  = 0;
                end
            end
        end
    endtask

    function automatic logic [6:0] exp_out(input int d);
        logic [3:0] g;
        logic [1:0] ix;
        if (m_owner[d] < 0) return 7'd0;
        g  = 4'b0001 << m_owner[d];
        ix = 2'(m_owner[d]);
        return {g, ix, 1'b1};
    endfunction

    function automatic logic [6:0] got_out(input int d);
        return (d == 0) ? {gnt8, idx8, v8} : {gnt2, idx2, v2};
    endfunction

    // One clock: advance the model with the req sampled at the edge, then
    // land on the falling edge and check the structural grant invariants.
    task automatic tick();
        logic [6:0] o;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(req);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = got_out(d);
            n_total++;
            if (!$onehot0(o[6:3]) || (o[0] != (o[6:3] != 4'b0000)) ||
                (o[0] && o[6:3] != (4'b0001 << o[2:1])) || (!o[0] && o[2:1] != 2'd0)) begin
                $display("FAIL invariant dut%0d t=%0t: gnt=%b idx=%0d valid=%b violates onehot/idx/valid rules",
                         d, $time, o[6:3], o[2:1], o[0]);
            end else n_pass++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        model_reset();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (got_out(d) !== 7'd0) $display("FAIL reset_hold dut%0d: got %b, need 0000_00_0", d, got_out(d));
            else n_pass++;
        end
        rst = 1'b0;
        req = 4'b0000;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (got_out(d) !== exp_out(d)) $display("FAIL reset_idle dut%0d: got %b, need %b", d, got_out(d), exp_out(d));
            else n_pass++;
        end
    endtask

    task automatic test_single_hold();
        logic [3:0] want;
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            want = (c % 9 == 8) ? 4'b0000 : 4'b0001;
            n_total++;
            if (gnt8 !== want) $display("FAIL single_hold8 cycle %0d: gnt=%b, need %b", c, gnt8, want);
            else n_pass++;
            n_total++;
            if (got_out(1) !== exp_out(1)) $display("FAIL single_hold2 cycle %0d: got %b, need %b", c, got_out(1), exp_out(1));
            else n_pass++;
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_all_req();
        int want;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            tick();
`ifdef ARB_RR_4_ROUND_ROBIN_EN
            want = (c / 2) % 4;
`else
            want = (c % 4 < 2) ? 3 : 2;
`endif
            n_total++;
            if (!v2 || idx2 !== 2'(want)) $display("FAIL all_req_seq cycle %0d: idx=%0d valid=%b, need idx=%0d valid=1", c, idx2, v2, want);
            else n_pass++;
            n_total++;
            if (got_out(0) !== exp_out(0)) $display("FAIL all_req_hold8 cycle %0d: got %b, need %b", c, got_out(0), exp_out(0));
            else n_pass++;
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_drop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (gnt8 !== 4'b0010) $display("FAIL drop_owner cycle %0d: gnt=%b, need 0010", c, gnt8);
            else n_pass++;
        end
        req = 4'b0100;
        tick();
        n_total++;
        if (gnt8 !== 4'b0100 || idx8 !== 2'd2) $display("FAIL drop_handoff: gnt=%b idx=%0d, need 0100 idx=2", gnt8, idx8);
        else n_pass++;
        n_total++;
        if (got_out(1) !== exp_out(1)) $display("FAIL drop_hold2: got %b, need %b", got_out(1), exp_out(1));
        else n_pass++;
        req = 4'b0000;
        tick();
        n_total++;
        if (gnt8 !== 4'b0000 || v8 !== 1'b0) $display("FAIL drop_idle: gnt=%b valid=%b, need 0000 valid=0", gnt8, v8);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] want;
        req = 4'b0100;
        tick();
        n_total++;
        if (gnt8 !== 4'b0100) $display("FAIL mid_pre_grant: gnt=%b, need 0100", gnt8);
        else n_pass++;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if ({gnt8, v8, gnt2, v2} !== 10'd0) $display("FAIL mid_async_reset: gnt8=%b v8=%b gnt2=%b v2=%b, need all 0", gnt8, v8, gnt2, v2);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        req = 4'b0101;
        tick();
`ifdef ARB_RR_4_ROUND_ROBIN_EN
        want = 4'b0001;
`else
        want = 4'b0100;
`endif
        n_total++;
        if (gnt8 !== want) $display("FAIL mid_restart: gnt=%b, need %b", gnt8, want);
        else n_pass++;
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 99) == 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                n_total++;
                if (got_out(d) !== exp_out(d))
                    $display("FAIL random dut%0d cycle %0d req=%b: got %b, need %b", d, c, req, got_out(d), exp_out(d));
                else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_hold();
        test_all_req();
        test_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_arb_rr_4
